dm_arbiter: RTL

- Two-requester round-robin arbiter that shares the single-port 128x32 data memory (7-bit word address, combinational read, write committed at posedge clk).
- Requester 0 is the CPU data port; requester 1 is the DMA/debug loader.
- Each access is a req/gnt handshake.
- A requester holding `lock` keeps ownership for bounded bursts.
- Read data is returned registered, one cycle after the granted beat.

---
 rtl/dm_arbiter_if.sv | 42 ++++
 rtl/dm_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port data-memory arbiter.
// slave = arbiter side, master = requesters plus the memory model.
interface dm_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic          lock0;
    logic          lock1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] m_addr;
    logic          m_rd;
    logic          m_wr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, m_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output m_addr, m_rd, m_wr, m_wdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, m_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  m_addr, m_rd, m_wr, m_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory.
// Locked bursts are bounded to MAX_BURST beats once the other side is waiting.
module dm_arbiter #(
    parameter int AW        = 7,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input logic         clk,
    input logic         rst_n,
    dm_arbiter_if.slave bus
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          own_sel;
    logic          own_req;
    logic          own_we;
    logic          own_lock;
    logic          oth_req;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          gnt0;
    logic          gnt1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rd;
    logic          m_wr;

    // Grants are gated by rst_n so a reset edge can never commit a write.
    always_comb begin
        own_sel   = (state_q == OWN1);
        own_req   = own_sel ? bus.req1   : bus.req0;
        own_we    = own_sel ? bus.we1    : bus.we0;
        own_lock  = own_sel ? bus.lock1  : bus.lock0;
        oth_req   = own_sel ? bus.req0   : bus.req1;
        own_addr  = own_sel ? bus.addr1  : bus.addr0;
        own_wdata = own_sel ? bus.wdata1 : bus.wdata0;

        gnt0 = rst_n && (state_q == OWN0) && bus.req0;
        gnt1 = rst_n && (state_q == OWN1) && bus.req1;

        m_addr  = '0;
        m_wdata = '0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        if (gnt0 || gnt1) begin
            m_addr  = own_addr;
            m_wdata = own_wdata;
            m_wr    = own_we;
            m_rd    = ~own_we;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        burst_d = burst_q;

        unique case (state_q)
            IDLE: begin
                burst_d = '0;
                if (bus.req0 && bus.req1) begin
                    state_d = prio_q ? OWN1 : OWN0;
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    state_d = IDLE;
                    burst_d = '0;
                end else if (!own_lock || (oth_req && (burst_q == BURST_LAST))) begin
                    state_d = IDLE;
                    prio_d  = ~own_sel;
                    burst_d = '0;
                end else if (burst_q != BURST_LAST) begin
                    // Saturating: a long uncontested burst still yields one beat after contention.
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase

        rvalid0_d = gnt0 & ~bus.we0;
        rvalid1_d = gnt1 & ~bus.we1;
        rdata0_d  = rvalid0_d ? bus.m_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.m_rdata : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            burst_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            burst_q   <= burst_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.m_addr  = m_addr;
    assign bus.m_wdata = m_wdata;
    assign bus.m_rd    = m_rd;
    assign bus.m_wr    = m_wr;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

endmodule
